// File: rtl/booth_iter_mult_if.sv
// booth_iter_mult_if: operand/select input handshake and product output handshake of booth_iter_mult
// master drives operands, digit selects, in_valid_i and out_ready_i; slave returns in_ready_o, out_valid_o, product_o, sel_err_o
interface booth_iter_mult_if #(parameter int WIDTH = 8);
  localparam int ND = WIDTH / 2 + 1;
  logic in_valid_i;
  logic in_ready_o;
  logic [WIDTH-1:0] multiplicand_i;
  logic unsigned_i;
  logic [ND-1:0] is_zero_i;
  logic [ND-1:0] is_pos_one_i;
  logic [ND-1:0] is_pos_double_i;
  logic [ND-1:0] is_neg_one_i;
  logic [ND-1:0] is_neg_double_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [2*WIDTH-1:0] product_o;
  logic sel_err_o;
  modport master (
    output in_valid_i, multiplicand_i, unsigned_i, is_zero_i, is_pos_one_i, is_pos_double_i,
           is_neg_one_i, is_neg_double_i, out_ready_i,
    input  in_ready_o, out_valid_o, product_o, sel_err_o
  );
  modport slave (
    input  in_valid_i, multiplicand_i, unsigned_i, is_zero_i, is_pos_one_i, is_pos_double_i,
           is_neg_one_i, is_neg_double_i, out_ready_i,
    output in_ready_o, out_valid_o, product_o, sel_err_o
  );
endinterface

// File: rtl/booth_iter_mult.sv
// booth_iter_mult: iterative radix-4 Booth multiplier, one partial product per cycle from one-hot digit selects
// ports: clk_i, rst_i (async, active-high), bus (booth_iter_mult_if.slave: operand handshake in, product handshake out)
module booth_iter_mult #(
  parameter int WIDTH = 8
) (
  input logic clk_i,
  input logic rst_i,
  booth_iter_mult_if.slave bus
);
  localparam int ND = WIDTH / 2 + 1;
  localparam int AW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 2;
  localparam int IW = $clog2(ND);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] a_q, pp;
  logic [PW-1:0] acc, ppx;
  logic [ND-1:0] z_q, p1_q, p2_q, n1_q, n2_q;
  logic [IW-1:0] idx;
  logic [4:0] sel;
  logic err, legal, last;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    last = idx == IW'(ND - 1);
    state_nxt = state == IDLE ? (bus.in_valid_i ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                (bus.out_ready_i ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready_o = state == IDLE;
    bus.out_valid_o = state == DONE;
    bus.product_o = acc[2*WIDTH-1:0];
    bus.sel_err_o = err;
  end
  // a malformed digit select contributes nothing and is flagged instead
  always_comb begin
    sel = {z_q[idx], p1_q[idx], p2_q[idx], n1_q[idx], n2_q[idx]};
    legal = $onehot(sel);
    pp = !legal ? '0 :
         sel[3] ? a_q :
         sel[2] ? a_q << 1 :
         sel[1] ? -a_q :
         sel[0] ? -(a_q << 1) : '0;
    ppx = {{(PW - AW){pp[AW-1]}}, pp} << {idx, 1'b0};
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      a_q <= '0;
      z_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      n1_q <= '0;
      n2_q <= '0;
      acc <= '0;
      idx <= '0;
      err <= 1'b0;
    end else if (state == IDLE && bus.in_valid_i) begin
      a_q <= bus.unsigned_i ? {2'b00, bus.multiplicand_i} : {{2{bus.multiplicand_i[WIDTH-1]}}, bus.multiplicand_i};
      z_q <= bus.is_zero_i;
      p1_q <= bus.is_pos_one_i;
      p2_q <= bus.is_pos_double_i;
      n1_q <= bus.is_neg_one_i;
      n2_q <= bus.is_neg_double_i;
      acc <= '0;
      idx <= '0;
      err <= 1'b0;
    end else if (state == BUSY) begin
      acc <= acc + ppx;
      idx <= idx + 1'b1;
      err <= err | ~legal;
    end
endmodule

// File: tb/tb_booth_iter_mult.sv
// tb_booth_iter_mult: table-driven and sequence checks of booth_iter_mult at WIDTH=8
module tb_booth_iter_mult;
  localparam int W = 8;
  localparam int ND = W / 2 + 1;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic uns;
    logic bad;
    logic [2*W-1:0] prod;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  vec_t vt[13];
  always #5 clk = ~clk;
  booth_iter_mult_if #(.WIDTH(W)) bus();
  booth_iter_mult #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // radix-4 Booth encoding of the multiplier, as the upstream encoder produces it
  task automatic drive_sel(input logic [W-1:0] b, input logic uns, input logic bad);
    logic [W+2:0] bs;
    logic [2:0] t;
    int d;
    bs = uns ? {2'b00, b, 1'b0} : {{2{b[W-1]}}, b, 1'b0};
    for (int k = 0; k < ND; k++) begin
      t = bs[2*k +: 3];
      d = int'(t[1]) + int'(t[0]) - 2 * int'(t[2]);
      bus.is_zero_i[k] = d == 0;
      bus.is_pos_one_i[k] = d == 1;
      bus.is_pos_double_i[k] = d == 2;
      bus.is_neg_one_i[k] = d == -1;
      bus.is_neg_double_i[k] = d == -2;
    end
    if (bad) bus.is_neg_one_i[1] = 1'b1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
    logic signed [2*W-1:0] s;
    logic [2*W-1:0] u;
    u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    s = $signed(a) * $signed(b);
    return uns ? u : s;
  endfunction

  // presents one operation, returns half a cycle after the accept edge with the inputs scrambled
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns, input logic bad);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.multiplicand_i = a;
    bus.unsigned_i = uns;
    drive_sel(b, uns, bad);
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.multiplicand_i = W'($urandom);
    bus.unsigned_i = ~uns;
    bus.is_zero_i = ND'($urandom);
    bus.is_pos_one_i = ND'($urandom);
    bus.is_neg_double_i = ND'($urandom);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.out_valid_o && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    int e, n;
    logic [W-1:0] ra[3], rb[3];
    logic ru;
    logic [W-1:0] xa, xb;
    logic seen;
    vt[0]  = '{8'hFD, 8'h05, 1'b0, 1'b0, 16'hFFF1, 1'b0};
    vt[1]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFE01, 1'b0};
    vt[2]  = '{8'h80, 8'h80, 1'b0, 1'b0, 16'h4000, 1'b0};
    vt[3]  = '{8'h80, 8'h7F, 1'b0, 1'b0, 16'hC080, 1'b0};
    vt[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    vt[5]  = '{8'h7F, 8'h7F, 1'b0, 1'b0, 16'h3F01, 1'b0};
    vt[6]  = '{8'h03, 8'h05, 1'b0, 1'b1, 16'h0003, 1'b1};
    vt[7]  = '{8'hC8, 8'h03, 1'b1, 1'b0, 16'h0258, 1'b0};
    vt[8]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'h0001, 1'b0};
    vt[9]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 16'h00FF, 1'b0};
    vt[10] = '{8'h7F, 8'hFF, 1'b0, 1'b0, 16'hFF81, 1'b0};
    vt[11] = '{8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 1'b0};
    vt[12] = '{8'h55, 8'hAA, 1'b0, 1'b0, 16'hE372, 1'b0};
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.multiplicand_i = '0;
    bus.unsigned_i = 1'b0;
    drive_sel('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready_o), 1);
    check("reset_out_valid", 32'(bus.out_valid_o), 0);
    check("reset_product", 32'(bus.product_o), 0);
    check("reset_sel_err", 32'(bus.sel_err_o), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      start_op(vt[i].a, vt[i].b, vt[i].uns, vt[i].bad);
      wait_done(e);
      // edges counted include the accept edge
      check($sformatf("latency[%0d]", i), e + 1, ND + 1);
      check($sformatf("product[%0d]", i), 32'(bus.product_o), 32'(vt[i].prod));
      check($sformatf("sel_err[%0d]", i), 32'(bus.sel_err_o), 32'(vt[i].err));
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    check("idle_out_valid", 32'(bus.out_valid_o), 0);
    check("idle_product_hold", 32'(bus.product_o), 32'(vt[12].prod));
    check("idle_in_ready", 32'(bus.in_ready_o), 1);

    bus.out_ready_i = 1'b0;
    start_op(8'h80, 8'h7F, 1'b0, 1'b0);
    wait_done(e);
    check("bp_done", 32'(bus.out_valid_o), 1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_product[%0d]", c), 32'(bus.product_o), 32'hC080);
      check($sformatf("bp_out_valid[%0d]", c), 32'(bus.out_valid_o), 1);
      check($sformatf("bp_in_ready[%0d]", c), 32'(bus.in_ready_o), 0);
    end
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(bus.out_valid_o), 0);
    check("bp_release_in_ready", 32'(bus.in_ready_o), 1);
    check("bp_release_product", 32'(bus.product_o), 32'hC080);

    for (int i = 0; i < 3; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
    end
    @(negedge clk);
    bus.multiplicand_i = ra[0];
    bus.unsigned_i = 1'b0;
    drive_sel(rb[0], 1'b0, 1'b0);
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!bus.in_ready_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      check($sformatf("b2b_busy[%0d]", i), 32'(bus.in_ready_o), 0);
      @(negedge clk);
      if (i < 2) begin
        bus.multiplicand_i = ra[i+1];
        drive_sel(rb[i+1], 1'b0, 1'b0);
      end else bus.in_valid_i = 1'b0;
      wait_done(e);
      check($sformatf("b2b_product[%0d]", i), 32'(bus.product_o), 32'(ref_mul(ra[i], rb[i], 1'b0)));
    end

    for (int i = 0; i < 1000; i++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      ru = i[0];
      start_op(xa, xb, ru, 1'b0);
      wait_done(e);
      check($sformatf("sweep_product[%0d]", i), 32'(bus.product_o), 32'(ref_mul(xa, xb, ru)));
      check($sformatf("sweep_sel_err[%0d]", i), 32'(bus.sel_err_o), 0);
    end

    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid_o), 0);
    check("rst_in_ready", 32'(bus.in_ready_o), 1);
    check("rst_product", 32'(bus.product_o), 0);
    check("rst_sel_err", 32'(bus.sel_err_o), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | bus.out_valid_o;
    end
    check("rst_no_output", 32'(seen), 0);
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(e);
    check("rst_next_latency", e + 1, ND + 1);
    check("rst_next_product", 32'(bus.product_o), 32'h03A8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
